// File: rtl/motor_pkg.sv
// Shared constants and FSM state type for the motor-feedback measurement blocks.
package motor_pkg;

    localparam int BAND_WIDTH         = 32;
    localparam int ONE_ROTATION_PULSE = 4096;
    localparam int SAMPLING_RATE      = 100;

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } meter_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period timer: counts 0..SAMPLE_CYCLES-1 and flags the terminal count for one cycle.
module sample_tick_gen #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int SAMPLING_RATE = 100
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic tick
);

    localparam int SAMPLE_CYCLES = CLK_FREQ / SAMPLING_RATE;
    localparam int CW            = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM_CNT = CW'(SAMPLE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == TERM_CNT)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A coincident clear restarts the period, so the terminal count is suppressed.
    assign tick = (cnt_q == TERM_CNT) && !clear;

endmodule

// File: rtl/rot_velocity_meter.sv
// Encoder velocity meter: per-period count delta plus an N-sample moving average.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   PRIME | waiting for first tick after reset/clear to latch a baseline
//   RUN   | every tick produces a delta and, one cycle later, an average
module rot_velocity_meter #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int SAMPLING_RATE  = motor_pkg::SAMPLING_RATE,
    parameter int BAND_WIDTH     = motor_pkg::BAND_WIDTH,
    parameter int AVG_DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [BAND_WIDTH-1:0] rot_cnt,
    input  logic                  clear,
    output logic [BAND_WIDTH-1:0] rot_delta,
    output logic [BAND_WIDTH-1:0] rot_v_avg,
    output logic                  valid,
    output logic                  avg_full
);

    import motor_pkg::*;

    localparam int N  = 1 << AVG_DEPTH_LOG2;
    localparam int SW = BAND_WIDTH + AVG_DEPTH_LOG2;
    localparam int PW = (AVG_DEPTH_LOG2 > 0) ? AVG_DEPTH_LOG2 : 1;
    localparam logic [PW-1:0] LAST_SLOT = PW'(N - 1);

    logic tick;

    sample_tick_gen #(
        .CLK_FREQ      (CLK_FREQ),
        .SAMPLING_RATE (SAMPLING_RATE)
    ) u_tick (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .tick  (tick)
    );

    meter_state_e          state_q, state_d;
    logic [BAND_WIDTH-1:0] prev_q, prev_d;
    logic [BAND_WIDTH-1:0] delta_q, delta_d;
    logic [BAND_WIDTH-1:0] avg_q, avg_d;
    logic                  upd_q, upd_d;
    logic                  valid_q, valid_d;
    logic                  full_q, full_d;
    logic [BAND_WIDTH-1:0] ring_q [N];
    logic [BAND_WIDTH-1:0] ring_d [N];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic signed [SW-1:0]  sum_q, sum_d;

    logic signed [BAND_WIDTH-1:0] new_s, old_s;
    logic signed [SW-1:0]         sum_next;
    logic signed [SW-1:0]         sum_shr;

    // The slot under wptr holds the oldest delta, which the new one replaces.
    always_comb begin
        new_s    = $signed(delta_q);
        old_s    = $signed(ring_q[wptr_q]);
        sum_next = sum_q + SW'(new_s) - SW'(old_s);
        sum_shr  = sum_next >>> AVG_DEPTH_LOG2;
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        delta_d = delta_q;
        avg_d   = avg_q;
        upd_d   = 1'b0;
        valid_d = 1'b0;
        full_d  = full_q;
        ring_d  = ring_q;
        wptr_d  = wptr_q;
        sum_d   = sum_q;

        if (clear) begin
            state_d = PRIME;
            delta_d = '0;
            avg_d   = '0;
            full_d  = 1'b0;
            wptr_d  = '0;
            sum_d   = '0;
            for (int i = 0; i < N; i++) begin
                ring_d[i] = '0;
            end
        end else begin
            if (tick) begin
                case (state_q)
                    PRIME: begin
                        prev_d  = rot_cnt;
                        state_d = RUN;
                    end
                    RUN: begin
                        delta_d = rot_cnt - prev_q;
                        prev_d  = rot_cnt;
                        upd_d   = 1'b1;
                    end
                    default: state_d = PRIME;
                endcase
            end

            if (upd_q) begin
                ring_d[wptr_q] = delta_q;
                wptr_d         = (wptr_q == LAST_SLOT) ? '0 : wptr_q + 1'b1;
                sum_d          = sum_next;
                avg_d          = sum_shr[BAND_WIDTH-1:0];
                valid_d        = 1'b1;
                // wptr starts at 0 after reset/clear, so reaching the last slot means N deltas.
                if (wptr_q == LAST_SLOT) begin
                    full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= PRIME;
            prev_q  <= '0;
            delta_q <= '0;
            avg_q   <= '0;
            upd_q   <= 1'b0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            wptr_q  <= '0;
            sum_q   <= '0;
            for (int i = 0; i < N; i++) begin
                ring_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            delta_q <= delta_d;
            avg_q   <= avg_d;
            upd_q   <= upd_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            wptr_q  <= wptr_d;
            sum_q   <= sum_d;
            for (int i = 0; i < N; i++) begin
                ring_q[i] <= ring_d[i];
            end
        end
    end

    assign rot_delta = delta_q;
    assign rot_v_avg = avg_q;
    assign valid     = valid_q;
    assign avg_full  = full_q;

endmodule

// File: tb/tb_rot_velocity_meter.sv
// Randomised scoreboard bench for rot_velocity_meter (10-cycle sample period, 4-deep average).
module tb_rot_velocity_meter;

    localparam int BW = 32;
    localparam int L  = 2;
    localparam int N  = 4;
    localparam int SC = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clear;
    logic [BW-1:0] rot_cnt;
    logic [BW-1:0] rot_delta;
    logic [BW-1:0] rot_v_avg;
    logic          valid;
    logic          avg_full;

    always #5 clk = ~clk;

    rot_velocity_meter #(
        .CLK_FREQ       (1000),
        .SAMPLING_RATE  (100),
        .BAND_WIDTH     (BW),
        .AVG_DEPTH_LOG2 (L)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rot_cnt   (rot_cnt),
        .clear     (clear),
        .rot_delta (rot_delta),
        .rot_v_avg (rot_v_avg),
        .valid     (valid),
        .avg_full  (avg_full)
    );

    typedef struct {
        int            due;
        logic [BW-1:0] delta;
        logic [BW-1:0] avg;
        logic          full;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model state: phase within the sample period and sample history.
    int            ph;
    bit            primed;
    bit            junk;
    logic [BW-1:0] prev;
    longint        hist[$];
    int            nfill;
    logic [BW-1:0] mon_avg;
    logic          mon_full;
    logic [BW-1:0] cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_sample(input logic [BW-1:0] v);
        exp_t          e;
        logic [BW-1:0] d;
        longint        s;
        d    = v - prev;
        prev = v;
        hist.push_back(longint'($signed(d)));
        if (hist.size() > N) void'(hist.pop_front());
        s = 0;
        foreach (hist[i]) s += hist[i];
        s = s >>> L;
        nfill++;
        e.due   = cyc + 2;
        e.delta = d;
        e.avg   = s[BW-1:0];
        e.full  = (nfill >= N);
        q.push_back(e);
    endfunction

    task automatic step(input bit clr, input logic [BW-1:0] v, output bit ticked);
        bit tk;
        tk      = (ph == SC - 1);
        ticked  = tk && !clr;
        clear   = clr;
        rot_cnt = tk ? v : (junk ? BW'($urandom) : rot_cnt);
        if (clr) begin
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
            primed = 0;
            hist.delete();
            nfill  = 0;
        end else if (tk) begin
            if (!primed) begin
                prev   = v;
                primed = 1;
            end else begin
                model_sample(v);
            end
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        if (clr) begin
            chk("clr_delta", rot_delta, '0);
            chk("clr_avg", rot_v_avg, '0);
            chk("clr_valid", {31'b0, valid}, '0);
            chk("clr_full", {31'b0, avg_full}, '0);
            mon_avg  = '0;
            mon_full = 1'b0;
            ph       = 0;
        end else begin
            ph = (ph + 1) % SC;
        end
    endtask

    task automatic run_tick(input logic [BW-1:0] v);
        bit t;
        t = 0;
        while (!t) step(0, v, t);
    endtask

    task automatic run_tick_rand(input logic [BW-1:0] v);
        bit t;
        t = 0;
        while (!t) step(($urandom_range(0, 24) == 0), v, t);
    endtask

    task automatic clear_now();
        bit t;
        step(1, cur, t);
    endtask

    task automatic pulse_reset(input int hold);
        rstn  = 1'b0;
        clear = 1'b0;
        #1;
        chk("rst_delta", rot_delta, '0);
        chk("rst_avg", rot_v_avg, '0);
        chk("rst_valid", {31'b0, valid}, '0);
        chk("rst_full", {31'b0, avg_full}, '0);
        q.delete();
        hist.delete();
        primed   = 0;
        nfill    = 0;
        prev     = '0;
        mon_avg  = '0;
        mon_full = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        rstn = 1'b1;
        ph   = 0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstn === 1'b1) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL valid_missing: no valid by cycle %0d, required at %0d", cyc, q[0].due);
                void'(q.pop_front());
            end
            if (valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", {31'b0, valid}, '0);
                end else begin
                    e = q.pop_front();
                    chk("valid_cycle", BW'(cyc), BW'(e.due));
                    chk("rot_delta", rot_delta, e.delta);
                    chk("rot_v_avg", rot_v_avg, e.avg);
                    chk("avg_full", {31'b0, avg_full}, {31'b0, e.full});
                    mon_avg  = e.avg;
                    mon_full = e.full;
                end
            end
            chk("avg_hold", rot_v_avg, mon_avg);
            chk("full_hold", {31'b0, avg_full}, {31'b0, mon_full});
        end
    end

    initial begin
        bit t;
        rstn     = 1'b0;
        clear    = 1'b0;
        rot_cnt  = '0;
        ph       = 0;
        junk     = 0;
        cur      = '0;
        mon_avg  = '0;
        mon_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pulse_reset(3);

        // Constant zero count: first tick only primes.
        repeat (3) run_tick('0);

        // Rising by 5 per period from a fresh start.
        junk = 1;
        clear_now();
        cur = 32'd1000;
        run_tick(cur);
        repeat (4) begin
            cur = cur + 32'd5;
            run_tick(cur);
        end

        // Falling by 3 per period.
        clear_now();
        cur = 32'd50;
        run_tick(cur);
        repeat (5) begin
            cur = cur - 32'd3;
            run_tick(cur);
        end

        // Clear coinciding with a tick while the average is full.
        while (ph != SC - 1) step(0, cur, t);
        step(1, cur, t);
        cur = cur + 32'd9;
        run_tick(cur);
        cur = cur + 32'd7;
        run_tick(cur);

        // Signed wrap of the encoder count.
        clear_now();
        cur = 32'h7FFF_FFFE;
        run_tick(cur);
        cur = 32'h8000_0001;
        run_tick(cur);
        cur = 32'h8000_0001 - 32'd6;
        run_tick(cur);

        // Random deltas, occasional clears, one mid-period reset.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) cur = cur + BW'($urandom);
            else cur = cur + BW'($urandom_range(0, 400)) - 32'd200;
            run_tick_rand(cur);
            if (i == 20) begin
                repeat ($urandom_range(2, 7)) step(0, cur, t);
                pulse_reset($urandom_range(1, 4));
            end
        end

        repeat (3) step(0, cur, t);
        chk("drain", BW'(q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rot_velocity_meter.md
ROT_VELOCITY_METER -- requirements
Module: rot_velocity_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLING_RATE, default 100: samples per second.
REQ-003 SHALL have parameter BAND_WIDTH, default 32: width of count and delta.
REQ-004 SHALL have parameter AVG_DEPTH_LOG2, default 2: log2 of moving-average depth N (N=4).
REQ-005 SHALL have port clk, input, 1: single system clock.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port rot_cnt, input, BAND_WIDTH: free-running signed encoder count from the quadrature counter.
REQ-008 SHALL have port clear, input, 1: synchronous restart of measurement.
REQ-009 SHALL have port rot_delta, output, BAND_WIDTH: signed count change over the last sample period.
REQ-010 SHALL have port rot_v_avg, output, BAND_WIDTH: signed N-sample moving average of rot_delta.
REQ-011 SHALL have port valid, output, 1: one-cycle pulse when rot_delta and rot_v_avg update.
REQ-012 SHALL have port avg_full, output, 1: high once N deltas have been accumulated since reset or clear.

Function
REQ-013 SHALL derive SAMPLE_CYCLES = CLK_FREQ / SAMPLING_RATE; tick counter runs 0..SAMPLE_CYCLES-1 and wraps; tick asserted for one cycle at terminal count.
REQ-014 SHALL implement FSM with states PRIME and RUN; reset and clear enter PRIME.
REQ-015 In PRIME, on tick SHALL capture rot_cnt into prev_cnt, go to RUN, assert no valid.
REQ-016 In RUN, on tick SHALL register rot_delta = rot_cnt - prev_cnt (modulo 2^BAND_WIDTH) and load prev_cnt = rot_cnt in the same cycle.
REQ-017 Counter wrap-around (e.g. 0x7FFFFFFF to 0x80000000) SHALL yield the correct small signed delta via two's-complement subtraction.
REQ-018 SHALL hold last N deltas in a ring buffer (zero-initialised) and a running sum of width BAND_WIDTH+AVG_DEPTH_LOG2: sum = sum + new - oldest.
REQ-019 rot_v_avg SHALL be sum arithmetically shifted right by AVG_DEPTH_LOG2 (floor toward minus infinity), truncated to BAND_WIDTH.
REQ-020 Latency: rot_delta valid 1 cycle after tick; rot_v_avg and valid pulse 2 cycles after tick; rot_delta held stable while valid high.
REQ-021 avg_full SHALL rise with the valid pulse carrying the Nth delta and stay high until reset or clear.
REQ-022 Outputs rot_delta and rot_v_avg SHALL hold their last values between valid pulses.
REQ-023 clear SHALL zero tick counter, ring buffer, sum, rot_delta, rot_v_avg, avg_full, valid and enter PRIME; clear dominates a coincident tick; any in-flight update is dropped.
REQ-024 Changes of rot_cnt between ticks SHALL have no effect; only the tick-cycle value is used.

Reset
REQ-025 On rstn low SHALL asynchronously set: state PRIME, tick counter 0, prev_cnt 0, ring buffer 0, sum 0, rot_delta 0, rot_v_avg 0, valid 0, avg_full 0.
REQ-026 Reset deasserted mid-period SHALL start a full SAMPLE_CYCLES period from counter 0.

Structure
REQ-027 BAND_WIDTH, ONE_ROTATION_PULSE, SAMPLING_RATE and the PRIME/RUN state enum typedef SHALL live in shared package motor_pkg.
REQ-028 Tick counter SHALL be a sub-module sample_tick_gen (params CLK_FREQ, SAMPLING_RATE; ports clk, rstn, clear, tick).

Verification (CLK_FREQ=1000, SAMPLING_RATE=100 -> SAMPLE_CYCLES=10, N=4)
REQ-029 Reset then rot_cnt=0 constant for 3 ticks -> no valid on tick 1; valid on ticks 2,3 with rot_delta=0, rot_v_avg=0.
REQ-030 rot_cnt +5 per period -> rot_delta=5; rot_v_avg 1,2,3,5 (floor 5/4,10/4,15/4,20/4) on successive valids; avg_full rises with the 4th.
REQ-031 rot_cnt decreasing 3 per period -> rot_delta=-3 (0xFFFFFFFD); rot_v_avg -1,-2,-3,-3.
REQ-032 rot_cnt 0x7FFFFFFE then 0x80000001 across a tick -> rot_delta=3.
REQ-033 clear asserted on a tick cycle after avg_full -> no valid 2 cycles later, all outputs 0, next tick primes only, following tick gives valid.
REQ-034 rstn pulsed low mid-period during RUN -> outputs 0 immediately (asynchronous), first valid exactly 2 ticks (20 cycles + 2) after release.
